// File: rtl/mesh_sim_traffic_gen.sv
// Mesh traffic generator: emits a run of sequence-numbered, LFSR-tagged flits
// round-robin over the enabled channels, with optional idle gaps and stall statistics.
module mesh_sim_traffic_gen #(
  parameter int          NUM_CH = 4,
  parameter int          DATA_W = 64,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_start,
  input  logic [CNT_W-1:0]                               cfg_num_flits,
  input  logic [NUM_CH-1:0]                              cfg_ch_mask,
  input  logic [3:0]                                     cfg_gap,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [DATA_W-1:0]                              out_data,
  output logic                                           busy,
  output logic                                           done,
  output logic [CNT_W-1:0]                               sent_cnt,
  output logic [CNT_W-1:0]                               stall_cnt
);

  localparam int          CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          UP_W = DATA_W - CNT_W - 8;
  localparam int          LF_W = (UP_W < 32) ? UP_W : 32;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_sent;
  logic [CNT_W-1:0]  r_stall;
  logic [NUM_CH-1:0] r_mask;
  logic [3:0]        r_gap;
  logic [3:0]        r_gap_cnt;
  logic [CH_W-1:0]   r_ch;
  logic [31:0]       r_lfsr;
  logic              w_start;
  logic              w_accept;
  logic              w_last;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // Next enabled channel strictly after cur, wrapping; searching from NUM_CH-1
  // therefore yields the lowest set bit.
  function automatic logic [CH_W-1:0] f_next_ch(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   cur);
    logic [CH_W-1:0] sel;
    logic            found;
    int              j;
    sel   = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = (int'(cur) + i) % NUM_CH;
      if (!found && (((mask >> j) & NUM_CH'(1)) != '0)) begin
        sel   = CH_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_start  = cfg_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_accept = (r_state == S_SEND) && out_ready;
    w_last   = (CNT_W'(r_sent + 1'b1) == r_num);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start)
          w_next = ((cfg_num_flits == '0) || (cfg_ch_mask == '0)) ? S_DONE : S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (w_accept) begin
          if (w_last)             w_next = S_DONE;
          else if (r_gap != 4'd0) w_next = S_GAP;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (r_gap_cnt <= 4'd1) w_next = S_SEND;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_start)
          w_next = ((cfg_num_flits == '0) || (cfg_ch_mask == '0)) ? S_DONE : S_SEND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register update independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num     <= '0;
      r_mask    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_sent    <= '0;
      r_stall   <= '0;
      r_ch      <= '0;
      r_lfsr    <= SEED;
    end else begin
      if (w_start) begin
        r_num   <= cfg_num_flits;
        r_mask  <= cfg_ch_mask;
        r_gap   <= cfg_gap;
        r_sent  <= '0;
        r_stall <= '0;
        r_ch    <= f_next_ch(cfg_ch_mask, CH_W'(NUM_CH - 1));
      end
      if (w_accept) begin
        r_sent    <= r_sent + 1'b1;
        r_lfsr    <= f_lfsr_step(r_lfsr);
        r_ch      <= f_next_ch(r_mask, r_ch);
        r_gap_cnt <= r_gap;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
      if ((r_state == S_SEND) && !out_ready && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
    end
  end

  // Payload is only meaningful while a flit is offered; it reads zero otherwise.
  always_comb begin
    out_data = '0;
    if (r_state == S_SEND) begin
      out_data[CNT_W-1:0]       = r_sent;
      out_data[CNT_W+7:CNT_W]   = 8'(r_ch);
      for (int i = 0; i < LF_W; i++)
        out_data[CNT_W+8+i] = r_lfsr[i];
    end
  end

  assign out_ch    = r_ch;
  assign sent_cnt  = r_sent;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_mesh_sim_traffic_gen.sv
// Directed bench for mesh_sim_traffic_gen: full-rate, gapped, stalled, empty,
// mid-run reset and start-while-busy runs against a small reference model.
module tb_mesh_sim_traffic_gen;

  localparam int          NUM_CH = 4;
  localparam int          DATA_W = 64;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] SEED   = 32'hACE1_0001;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_num_flits;
  logic [NUM_CH-1:0] cfg_ch_mask;
  logic [3:0]        cfg_gap;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sent_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_lfsr;
  int          exp_ch[16];

  mesh_sim_traffic_gen #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_flits(cfg_num_flits),
    .cfg_ch_mask(cfg_ch_mask), .cfg_gap(cfg_gap), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data), .busy(busy),
    .done(done), .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] num, input logic [3:0] mask,
                           input logic [3:0] gap);
    cfg_num_flits = num;
    cfg_ch_mask   = mask;
    cfg_gap       = gap;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_errors++; $display("FAIL %s flags got %b exp 000", name, {out_valid, busy, done});
    end
    n_checks++;
    if (out_ch !== 2'd0) begin
      n_errors++; $display("FAIL %s out_ch got %0d exp 0", name, out_ch);
    end
    n_checks++;
    if (out_data !== 64'h0) begin
      n_errors++; $display("FAIL %s out_data got %h exp 0", name, out_data);
    end
    n_checks++;
    if ({sent_cnt, stall_cnt} !== 32'h0) begin
      n_errors++; $display("FAIL %s counters got %h/%h exp 0/0", name, sent_cnt, stall_cnt);
    end
  endtask

  // Watches accepted flits from the current sample point until done, checking
  // channel, payload and spacing; optionally pulses cfg_start at cycle pulse_at.
  task automatic run_flits(input string name, input int n, input int spacing, input int pulse_at);
    int                k = 0;
    int                last = 0;
    int                c = 0;
    bit                seen_done = 1'b0;
    logic [DATA_W-1:0] exp_d;
    while (c < 400 && !seen_done) begin
      cfg_start = (c == pulse_at);
      if (c == pulse_at) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++; $display("FAIL %s busy_at_pulse got %b exp 1", name, busy);
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          n_checks++;
          if (k >= n) begin
            n_errors++; $display("FAIL %s extra_flit got %0d exp %0d", name, k + 1, n);
          end else begin
            exp_d = {8'h00, m_lfsr, 8'(exp_ch[k]), 16'(k)};
            if (out_ch !== 2'(exp_ch[k])) begin
              n_errors++; $display("FAIL %s ch[%0d] got %0d exp %0d", name, k, out_ch, exp_ch[k]);
            end
            n_checks++;
            if (out_data !== exp_d) begin
              n_errors++; $display("FAIL %s data[%0d] got %h exp %h", name, k, out_data, exp_d);
            end
            if (k > 0) begin
              n_checks++;
              if (c - last != spacing) begin
                n_errors++;
                $display("FAIL %s spacing[%0d] got %0d exp %0d", name, k, c - last, spacing);
              end
            end
          end
          last   = c;
          k++;
          m_lfsr = lfsr_next(m_lfsr);
        end
        tick();
        c++;
      end
    end
    cfg_start = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_errors++; $display("FAIL %s done_timeout got 0 exp 1", name);
    end
    n_checks++;
    if (k != n) begin
      n_errors++; $display("FAIL %s flit_count got %0d exp %0d", name, k, n);
    end
    n_checks++;
    if (sent_cnt !== CNT_W'(n)) begin
      n_errors++; $display("FAIL %s sent_cnt got %0d exp %0d", name, sent_cnt, n);
    end
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_errors++; $display("FAIL %s idle_after got %b exp 00", name, {busy, out_valid});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b1; cfg_num_flits = 16'd5; cfg_ch_mask = 4'hF;
    cfg_gap = 4'd0; out_ready = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0; cfg_start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_start_ignored busy got %b exp 0", busy);
    end
    m_lfsr = SEED;
  endtask

  task automatic test_full_rate();
    exp_ch = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    start_run(16'd8, 4'b1111, 4'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL full_rate busy got %b exp 1", busy);
    end
    run_flits("full_rate", 8, 1, -1);
    n_checks++;
    if (stall_cnt !== 16'd0) begin
      n_errors++; $display("FAIL full_rate stall_cnt got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_gap();
    exp_ch = '{1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start_run(16'd5, 4'b1010, 4'd2);
    run_flits("gap", 5, 3, -1);
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] d0;
    logic [1:0]        c0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lfsr = SEED;
    start_run(16'd2, 4'b0001, 4'd0);
    out_ready = 1'b0;
    d0 = out_data;
    c0 = out_ch;
    n_checks++;
    if (d0 !== {8'h00, 32'hACE1_0001, 8'h00, 16'h0000}) begin
      n_errors++; $display("FAIL stall first_data got %h exp 00ace1000100 0000", d0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_ch !== c0) begin
        n_errors++;
        $display("FAIL stall hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, c0, d0);
      end
      tick();
    end
    n_checks++;
    if (stall_cnt !== 16'd3) begin
      n_errors++; $display("FAIL stall stall_cnt got %0d exp 3", stall_cnt);
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_data[55:24] !== 32'hACE1_0001 || out_data[15:0] !== 16'd0) begin
      n_errors++; $display("FAIL stall accept0 got %h exp lfsr ace10001 seq 0", out_data);
    end
    tick();
    n_checks++;
    if (out_data[55:24] !== 32'hD650_8003 || out_data[15:0] !== 16'd1) begin
      n_errors++; $display("FAIL stall accept1 got %h exp lfsr d6508003 seq 1", out_data);
    end
    tick();
    m_lfsr = 32'hD650_8003;
    m_lfsr = lfsr_next(m_lfsr);
    n_checks++;
    if (done !== 1'b1 || sent_cnt !== 16'd2 || stall_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL stall end got done=%b sent=%0d stall=%0d exp 1/2/3", done, sent_cnt, stall_cnt);
    end
  endtask

  task automatic test_empty();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) start_run(16'd0, 4'b1111, 4'd3);
      else        start_run(16'd4, 4'b0000, 4'd0);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL empty%0d cycle1 got v=%b busy=%b exp 0/0", v, out_valid, busy);
      end
      tick();
      n_checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || sent_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
        n_errors++;
        $display("FAIL empty%0d cycle2 got done=%b v=%b sent=%0d stall=%0d exp 1/0/0/0",
                 v, done, out_valid, sent_cnt, stall_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_run(16'd10, 4'b1111, 4'd0);
    tick();
    tick();
    tick();
    n_checks++;
    if (sent_cnt !== 16'd3) begin
      n_errors++; $display("FAIL reset_mid sent_before got %0d exp 3", sent_cnt);
    end
    rst = 1'b1;
    tick();
    check_reset_values("reset_mid");
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || sent_cnt !== 16'd0) begin
      n_errors++; $display("FAIL reset_mid no_resume got v=%b sent=%0d exp 0/0", out_valid, sent_cnt);
    end
    m_lfsr = SEED;
    exp_ch = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start_run(16'd2, 4'b0011, 4'd0);
    run_flits("after_reset", 2, 1, -1);
  endtask

  task automatic test_back_to_back_start();
    exp_ch = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    start_run(16'd4, 4'b1111, 4'd1);
    cfg_num_flits = 16'd9;
    cfg_ch_mask   = 4'b0001;
    cfg_gap       = 4'd0;
    run_flits("busy_start", 4, 2, 1);
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_gap();
    test_stall();
    test_empty();
    test_reset_mid();
    test_back_to_back_start();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesh_sim_traffic_gen.md
MESH_SIM_TRAFFIC_GEN -- requirements
Module: mesh_sim_traffic_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of mesh channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 64, meaning flit width; DATA_W >= CNT_W+8.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the flit counter.
REQ-004 SHALL have parameter SEED, default 32'hACE1_0001, meaning LFSR reset value; must be nonzero.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port cfg_start, input, 1, start pulse.
REQ-008 SHALL have port cfg_num_flits, input, CNT_W, total flits to send.
REQ-009 SHALL have port cfg_ch_mask, input, NUM_CH, enabled channels.
REQ-010 SHALL have port cfg_gap, input, 4, idle cycles inserted after each accepted flit.
REQ-011 SHALL have port out_valid, output, 1, flit valid.
REQ-012 SHALL have port out_ready, input, 1, sink accepts flit.
REQ-013 SHALL have port out_ch, output, max(1,$clog2(NUM_CH)), channel of the current flit.
REQ-014 SHALL have port out_data, output, DATA_W, flit payload.
REQ-015 SHALL have port busy, output, 1, run in progress.
REQ-016 SHALL have port done, output, 1, run complete; held until the next accepted start.
REQ-017 SHALL have port sent_cnt, output, CNT_W, flits accepted in this run.
REQ-018 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, GAP, DONE.
REQ-020 SHALL, in IDLE or DONE, on cfg_start=1, latch cfg_num_flits, cfg_ch_mask and cfg_gap, clear sent_cnt and stall_cnt, clear done, and go to SEND next cycle.
REQ-021 SHALL, at start, go to DONE instead of SEND if the latched num_flits is 0 or the latched mask is 0.
REQ-022 SHALL ignore cfg_start while busy=1.
REQ-023 SHALL assert busy=1 exactly when the state is SEND or GAP.
REQ-024 SHALL, in SEND, drive out_valid=1 and hold out_ch and out_data stable until out_ready=1.
REQ-025 SHALL treat a flit as accepted when out_valid and out_ready are both 1 in a cycle, and then increment sent_cnt and advance the LFSR.
REQ-026 SHALL, after an accepted flit, go to DONE if sent_cnt+1 equals num_flits; otherwise go to GAP if gap>0, else stay in SEND.
REQ-027 SHALL therefore sustain one flit per cycle when gap=0 and out_ready stays high.
REQ-028 SHALL hold out_valid=0 in GAP for exactly gap cycles, then return to SEND.
REQ-029 SHALL select the channel of the first flit as the lowest set mask bit, and of each later flit as the next set bit above the previous channel, wrapping round-robin.
REQ-030 SHALL form out_data as [CNT_W-1:0] = sent_cnt (sequence number), [CNT_W+7:CNT_W] = {zero-extended out_ch}, and the remaining upper bits = LFSR[DATA_W-CNT_W-9:0], truncated or zero-extended as needed.
REQ-031 SHALL use a 32-bit Galois LFSR with taps mask 32'h8020_0003, shifting right with feedback from bit 0, advancing only on an accepted flit.
REQ-032 SHALL, in DONE, drive done=1 and out_valid=0.

Reset
REQ-033 SHALL, when rst=1 at a clock edge, force state IDLE, out_valid=0, out_ch=0, out_data=0, busy=0, done=0, sent_cnt=0, stall_cnt=0, LFSR=SEED, and all latched config to 0.
REQ-034 SHALL abort a run in progress on reset mid-operation, with no further flits, and SHALL ignore cfg_start in the reset cycle.

Verification
REQ-035 SHALL cover: NUM_CH=4, mask=4'b1111, num=8, gap=0, ready=1 -> 8 flits on consecutive cycles, ch 0,1,2,3,0,1,2,3, seq 0..7, then done=1, sent_cnt=8.
REQ-036 SHALL cover: mask=4'b1010, num=5, gap=2 -> ch 1,3,1,3,1, with exactly 2 idle cycles between flits.
REQ-037 SHALL cover: out_ready=0 for 3 cycles during the first flit -> out_data and out_ch stable throughout, stall_cnt=3, first accepted LFSR field = SEED bits.
REQ-038 SHALL cover: num=0 (or mask=0) -> done=1 two cycles after start, no out_valid, sent_cnt=0.
REQ-039 SHALL cover: rst asserted after 3 of 10 flits -> all outputs at reset values next cycle; a new start replays seq 0 with the LFSR reseeded to SEED.
REQ-040 SHALL cover: cfg_start pulsed while busy -> ignored, and the run completes with its original num_flits.
